// File: rtl/riscv_imem_if.sv
// riscv_imem_if: instruction-fetch front end with credit-limited pipelined bus and in-order prefetch FIFO
module riscv_imem_if #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32,
  parameter int DEPTH       = 4,
  parameter int MAX_OUT     = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [XLEN-1:0]        if_nxt_pc,
  output logic                   if_stall_nxt_pc,
  input  logic                   if_stall,
  input  logic                   if_flush,
  output logic [PARCEL_SIZE-1:0] if_parcel,
  output logic [XLEN-1:0]        if_parcel_pc,
  output logic [1:0]             if_parcel_valid,
  output logic                   if_parcel_misaligned,
  output logic                   if_parcel_page_fault,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_adr,
  input  logic                   imem_gnt,
  input  logic                   imem_ack,
  input  logic                   imem_err,
  input  logic [31:0]            imem_q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = MAX_OUT > 1 ? $clog2(MAX_OUT) : 1;
  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [PARCEL_SIZE-1:0] parcel;
    logic [1:0]             valid;
    logic                   mis;
    logic                   pf;
  } entry_t;
  entry_t          fifo [DEPTH];
  entry_t          head, resp, push_entry;
  logic [AW-1:0]   rp, wp;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] tags [MAX_OUT];
  logic [XLEN-1:0] tpc, mis_pc;
  logic [TW-1:0]   tr, tw;
  logic [OW-1:0]   outstanding, discard;
  logic [CW:0]     used;
  logic            run, mis_pend, can_issue, misalign_push, issue, keep, push, pop, head_valid;
  function automatic logic [TW-1:0] tinc(input logic [TW-1:0] p);
    return p == TW'(MAX_OUT - 1) ? '0 : p + 1'b1;
  endfunction
  // credit accounting, bus request, response formatting and head presentation
  always_comb begin
    used = (CW+1)'(count) + (CW+1)'(outstanding) + (CW+1)'(mis_pend);
    can_issue = run & !if_flush & (outstanding < OW'(MAX_OUT)) & (used < (CW+1)'(DEPTH));
    imem_req = can_issue & !if_nxt_pc[0];
    imem_adr = imem_req ? {if_nxt_pc[XLEN-1:2], 2'b00} : '0;
    misalign_push = can_issue & if_nxt_pc[0] & (outstanding == '0);
    issue = imem_req & imem_gnt;
    if_stall_nxt_pc = !(issue | misalign_push);
    keep = imem_ack & (discard == '0) & !if_flush;
    tpc = tags[tr];
    resp = '{pc: tpc,
             parcel: imem_err ? {PARCEL_SIZE{1'b0}} : tpc[1] ? {16'h0, imem_q[31:16]} : imem_q,
             valid: tpc[1] ? 2'b01 : 2'b11, mis: 1'b0, pf: imem_err};
    push_entry = mis_pend ? '{pc: mis_pc, parcel: {PARCEL_SIZE{1'b0}}, valid: 2'b01, mis: 1'b1, pf: 1'b0} : resp;
    push = keep | (mis_pend & !if_flush);
    head = fifo[rp];
    head_valid = (count != '0) & !if_flush;
    pop = head_valid & !if_stall;
    if_parcel = head_valid ? head.parcel : '0;
    if_parcel_pc = head_valid ? head.pc : '0;
    if_parcel_valid = head_valid ? head.valid : 2'b00;
    if_parcel_misaligned = head_valid & head.mis;
    if_parcel_page_fault = head_valid & head.pf;
  end
  // FIFO pointers and occupancy; flush empties the buffer outright
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else if (if_flush) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // FIFO storage; contents are masked at the output while empty
  always_ff @(posedge clk) begin
    if (push) fifo[wp] <= push_entry;
  end
  // tag queue pointers: one tag per live (non-discarded) request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tr <= '0;
      tw <= '0;
    end else if (if_flush) begin
      tr <= '0;
      tw <= '0;
    end else begin
      if (issue) tw <= tinc(tw);
      if (keep) tr <= tinc(tr);
    end
  end
  // tag storage holding the full fetch PC of each issued request
  always_ff @(posedge clk) begin
    if (issue) tags[tw] <= if_nxt_pc;
  end
  // in-flight and to-be-dropped response counters, start-up gate and misaligned hand-off
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outstanding <= '0;
      discard <= '0;
      run <= 1'b0;
      mis_pend <= 1'b0;
      mis_pc <= '0;
    end else begin
      outstanding <= outstanding + OW'(issue) - OW'(imem_ack);
      discard <= if_flush ? outstanding - OW'(imem_ack) : discard - OW'(imem_ack & (discard != '0));
      run <= 1'b1;
      mis_pend <= misalign_push;
      mis_pc <= if_nxt_pc;
    end
  end
  // the credit rule must keep the bus within its outstanding limit
  always_ff @(posedge clk) begin
    if (rstn) assert (outstanding <= OW'(MAX_OUT));
  end
endmodule
